sign_mag_table_loader: RTL

- Builds the 4-bit sign-magnitude adder truth table in hardware at run time and writes it into an internal synchronous RAM.
- Replaces file-based ROM initialisation: no $readmemb, no host-side table file.
- Once loaded, serves lookups on the same {input1, input2} address map as the synchronous ROM adder, so it is a drop-in lookup source.

---
 rtl/sign_mag_pkg.sv | 43 ++++
 rtl/sign_mag_ram.sv | 23 ++
 rtl/sign_mag_table_loader.sv | 95 +++++++++
 3 files changed

// File: rtl/sign_mag_pkg.sv
// Shared types, sizes and the sign-magnitude adder rule used to build the
// lookup table at run time.
package sign_mag_pkg;

   localparam int DEF_OUTPUT_WIDTH = 4;
   localparam int DEF_DATA_WIDTH   = 2 * DEF_OUTPUT_WIDTH;
   localparam int MAG_W            = DEF_OUTPUT_WIDTH - 1;
   localparam int TABLE_DEPTH      = 2 ** DEF_DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Magnitude overflow wraps silently; a zero magnitude always becomes +0.
   function automatic logic [DEF_OUTPUT_WIDTH-1:0] sign_mag_add(
      input logic [DEF_OUTPUT_WIDTH-1:0] a,
      input logic [DEF_OUTPUT_WIDTH-1:0] b
   );
      logic             sa, sb, sgn;
      logic [MAG_W-1:0] ma, mb, mag;
      sa = a[DEF_OUTPUT_WIDTH-1];
      sb = b[DEF_OUTPUT_WIDTH-1];
      ma = a[MAG_W-1:0];
      mb = b[MAG_W-1:0];
      if (sa == sb) begin
         mag = ma + mb;
         sgn = sa;
      end else if (ma >= mb) begin
         mag = ma - mb;
         sgn = sa;
      end else begin
         mag = mb - ma;
         sgn = sb;
      end
      if (mag == '0) begin
         return '0;
      end
      return {sgn, mag};
   endfunction

endpackage

// File: rtl/sign_mag_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module sign_mag_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/sign_mag_table_loader.sv
// Fills an internal RAM with the sign-magnitude adder table on start, then
// serves registered lookups addressed by {input1, input2}.
module sign_mag_table_loader
   import sign_mag_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    ready,
   input  logic [OUTPUT_WIDTH-1:0] input1,
   input  logic [OUTPUT_WIDTH-1:0] input2,
   output logic [OUTPUT_WIDTH-1:0] r_data
);

   localparam logic [DATA_WIDTH-1:0] LAST_ADDR = DATA_WIDTH'(TABLE_DEPTH - 1);

   state_t                  state, state_next;
   logic [DATA_WIDTH-1:0]   cnt, cnt_next;
   logic                    done_q, done_next;
   logic                    rd_valid_q;
   logic                    we;
   logic [OUTPUT_WIDTH-1:0] wdata;
   logic [OUTPUT_WIDTH-1:0] ram_rdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         done_q     <= done_next;
         rd_valid_q <= (state == DONE);
      end
   end

   // The write of the last address is what flips the FSM into DONE.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      done_next  = 1'b0;
      we         = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = WRITE;
               cnt_next   = '0;
            end
         end
         WRITE: begin
            we       = 1'b1;
            cnt_next = cnt + 1'b1;
            if (cnt == LAST_ADDR) begin
               state_next = DONE;
               done_next  = 1'b1;
            end
         end
         DONE: begin
            if (start) begin
               state_next = WRITE;
               cnt_next   = '0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign wdata = sign_mag_add(cnt[DATA_WIDTH-1 -: OUTPUT_WIDTH], cnt[OUTPUT_WIDTH-1:0]);

   sign_mag_ram #(
      .ADDR_W (DATA_WIDTH),
      .DATA_W (OUTPUT_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (cnt),
      .wdata (wdata),
      .raddr ({input1, input2}),
      .rdata (ram_rdata)
   );

   // Reads taken while the table was not valid are forced to zero.
   assign r_data = rd_valid_q ? ram_rdata : '0;
   assign busy   = (state == WRITE);
   assign ready  = (state == DONE);
   assign done   = done_q;

endmodule
